bcd_to_binary_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bcd_to_binary_seq.sv | 127 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned MAG_W   = 10;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned CNT_W   = 4;

  localparam int unsigned N_ITER  = 10;
  localparam int unsigned POS_MAX = 127;
  localparam int unsigned NEG_MAX = 128;

  localparam logic [OUT_W-1:0] SAT_POS = 8'h7F;
  localparam logic [OUT_W-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // A BCD digit above 9 cannot be converted.
  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 when the digit is 8 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj_c
);

  assign adj_c = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit signed BCD to 8-bit two's-complement converter with
// saturation and bad-digit detection; one bit of magnitude per CONV cycle.
module bcd_to_binary_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             neg,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] binary,
  output logic             overflow,
  output logic             bad_digit
);

  state_t             state, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;
  logic               busy_d, done_d, overflow_d, bad_digit_d;
  logic [OUT_W-1:0]   binary_d;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;

  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};

  bcd_digit_adj u_adj_ones (.digit(bcd_shift[3:0]),  .adj_c(bcd_adj[3:0]));
  bcd_digit_adj u_adj_tens (.digit(bcd_shift[7:4]),  .adj_c(bcd_adj[7:4]));
  bcd_digit_adj u_adj_hund (.digit(bcd_shift[11:8]), .adj_c(bcd_adj[11:8]));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    bcd_d       = bcd_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    err_d       = err_q;
    done_d      = 1'b0;
    binary_d    = binary;
    overflow_d  = overflow;
    bad_digit_d = bad_digit;

    case (state)
      IDLE: begin
        if (start) begin
          neg_d   = neg;
          bcd_d   = {hundreds, tens, ones};
          mag_d   = '0;
          cnt_d   = '0;
          err_d   = digit_bad(hundreds) | digit_bad(tens) | digit_bad(ones);
          state_d = err_d ? FINISH : CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_adj;
        mag_d = {bcd_q[0], mag_q[MAG_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_ITER - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d      = 1'b1;
        state_d     = IDLE;
        bad_digit_d = err_q;
        overflow_d  = 1'b0;
        if (err_q) begin
          binary_d = '0;
        end else if (!neg_q) begin
          if (mag_q > MAG_W'(POS_MAX)) begin
            binary_d   = SAT_POS;
            overflow_d = 1'b1;
          end else begin
            binary_d = mag_q[OUT_W-1:0];
          end
        end else begin
          // Negating zero yields zero, so there is no negative zero.
          if (mag_q > MAG_W'(NEG_MAX)) begin
            binary_d   = SAT_NEG;
            overflow_d = 1'b1;
          end else begin
            binary_d = ~mag_q[OUT_W-1:0] + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcd_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      binary    <= '0;
      overflow  <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      state     <= state_d;
      bcd_q     <= bcd_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      busy      <= busy_d;
      done      <= done_d;
      binary    <= binary_d;
      overflow  <= overflow_d;
      bad_digit <= bad_digit_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed table, random vectors
// against a decimal-arithmetic model, and multi-cycle corner sequences.
module tb_bcd_to_binary_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       neg;
  logic [3:0] hundreds, tens, ones;
  logic       busy, done, overflow, bad_digit;
  logic [7:0] binary;

  int n_vec = 0;
  int n_err = 0;

  bcd_to_binary_seq dut (
    .clk(clk), .rst(rst), .start(start), .neg(neg),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy), .done(done), .binary(binary),
    .overflow(overflow), .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       n;
    logic [3:0] h, t, o;
    logic [7:0] bin;
    logic       ov;
    logic       bd;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal value, then saturate into 8-bit two's complement.
  task automatic model(input logic n, input logic [3:0] h, input logic [3:0] t,
                       input logic [3:0] o, output logic [7:0] b, output logic ov,
                       output logic bd);
    int v;
    bd = (h > 9) || (t > 9) || (o > 9);
    ov = 1'b0;
    b  = 8'h00;
    if (!bd) begin
      v = int'(h) * 100 + int'(t) * 10 + int'(o);
      if (!n) begin
        if (v > 127) begin b = 8'h7F; ov = 1'b1; end
        else b = 8'(v);
      end else begin
        if (v > 128) begin b = 8'h80; ov = 1'b1; end
        else b = 8'(-v);
      end
    end
  endtask

  // Present a start for one edge; returns #1 after that edge with inputs scrambled.
  task automatic launch(input logic n, input logic [3:0] h, input logic [3:0] t,
                        input logic [3:0] o);
    @(negedge clk);
    neg = n; hundreds = h; tens = t; ones = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    neg = 1'($urandom); hundreds = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
  endtask

  // Count edges until done is seen; -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic n, input logic [3:0] h,
                           input logic [3:0] t, input logic [3:0] o,
                           input logic [7:0] eb, input logic eov, input logic ebd,
                           input int elat);
    int lat;
    launch(n, h, t, o);
    check({name, " busy_after_start"}, 32'(busy), 32'(1));
    wait_done(lat);
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " binary"}, 32'(binary), 32'(eb));
    check({name, " overflow"}, 32'(overflow), 32'(eov));
    check({name, " bad_digit"}, 32'(bad_digit), 32'(ebd));
    check({name, " busy_at_done"}, 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    check({name, " done_width"}, 32'(done), 32'(0));
    check({name, " binary_held"}, 32'(binary), 32'(eb));
  endtask

  vec_t tbl[$];

  initial begin
    logic [7:0] eb;
    logic       eov, ebd;
    logic [3:0] rh, rt, ro;
    logic       rn;
    int         lat;

    rst = 1'b1; start = 1'b0; neg = 1'b0; hundreds = '0; tens = '0; ones = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset binary", 32'(binary), 32'(0));
    check("reset overflow", 32'(overflow), 32'(0));
    check("reset bad_digit", 32'(bad_digit), 32'(0));
    rst = 1'b0;

    // Directed table: {neg, h, t, o, binary, overflow, bad_digit, latency}.
    tbl.push_back('{1'b0, 4'd0, 4'd2, 4'd5, 8'h19, 1'b0, 1'b0, 11});
    tbl.push_back('{1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0, 11});
    tbl.push_back('{1'b0, 4'd1, 4'd2, 4'd8, 8'h7F, 1'b1, 1'b0, 11});
    tbl.push_back('{1'b1, 4'd9, 4'd9, 4'd9, 8'h80, 1'b1, 1'b0, 11});
    tbl.push_back('{1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 11});
    tbl.push_back('{1'b1, 4'd0, 4'd0, 4'd1, 8'hFF, 1'b0, 1'b0, 11});
    tbl.push_back('{1'b0, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 1'b0, 11});
    tbl.push_back('{1'b1, 4'd1, 4'd2, 4'd9, 8'h80, 1'b1, 1'b0, 11});
    tbl.push_back('{1'b0, 4'd0, 4'hA, 4'd0, 8'h00, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b0, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0, 11});
    tbl.push_back('{1'b1, 4'hF, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, 4'd0, 4'd9, 4'd9, 8'h9D, 1'b0, 1'b0, 11});
    foreach (tbl[i])
      run_check($sformatf("tbl%0d", i), tbl[i].n, tbl[i].h, tbl[i].t, tbl[i].o,
                tbl[i].bin, tbl[i].ov, tbl[i].bd, tbl[i].lat);

    // Random vectors; digit range slightly exceeds 9 to exercise bad_digit.
    for (int i = 0; i < 40; i++) begin
      rn = 1'($urandom);
      rh = 4'($urandom_range(0, 11));
      rt = 4'($urandom_range(0, 10));
      ro = 4'($urandom_range(0, 10));
      if (i % 3 == 0) rh = 4'($urandom_range(0, 1));
      model(rn, rh, rt, ro, eb, eov, ebd);
      run_check($sformatf("rnd%0d", i), rn, rh, rt, ro, eb, eov, ebd, ebd ? 1 : 11);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(1'b0, 4'd0, 4'd4, 4'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    neg = 1'b1; hundreds = 4'd0; tens = 4'd0; ones = 4'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("busy_start latency", 32'(lat), 32'(7));
    check("busy_start binary", 32'(binary), 32'(8'h2A));
    neg = 1'b0; hundreds = 4'd1; tens = 4'd0; ones = 4'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_cycle start busy", 32'(busy), 32'(1));
    check("done_cycle start done", 32'(done), 32'(0));
    wait_done(lat);
    check("done_cycle latency", 32'(lat), 32'(11));
    check("done_cycle binary", 32'(binary), 32'(8'h64));
    @(posedge clk);
    #1;
    check("no queued start", 32'(busy), 32'(0));

    // Reset at edge 5 aborts; start in the first cycle after reset works.
    launch(1'b1, 4'd0, 4'd5, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst done", 32'(done), 32'(0));
    check("midrst binary", 32'(binary), 32'(0));
    check("midrst overflow", 32'(overflow), 32'(0));
    check("midrst bad_digit", 32'(bad_digit), 32'(0));
    run_check("after_rst", 1'b1, 4'd0, 4'd2, 4'd5, 8'hE7, 1'b0, 1'b0, 11);

    // Idle with no start: no spurious done.
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) lat++;
    end
    check("idle no done", 32'(lat), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
